// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned CH_NUM         = 4;
  localparam int unsigned DEFAULT_WIDTH  = 4;
  localparam int unsigned DEFAULT_SWIDTH = 2;

  localparam logic [1:0] SEL_CH0 = 2'b00;
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;
  localparam logic [1:0] SEL_CH3 = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [CH_NUM-1:0] sel_decode(input logic [1:0] s);
    logic [CH_NUM-1:0] onehot;
    onehot = '0;
    case (s)
      SEL_CH0: onehot[0] = 1'b1;
      SEL_CH1: onehot[1] = 1'b1;
      SEL_CH2: onehot[2] = 1'b1;
      SEL_CH3: onehot[3] = 1'b1;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice: holds a word until the consumer takes it,
// and can be drained and refilled in the same cycle.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  input  logic             rd_ready,
  output logic             valid,
  output logic [width-1:0] data,
  output logic             wr_ok
);

  slot_state_e state, state_nxt;
  logic        fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLOT_EMPTY: if (fill) state_nxt = SLOT_FULL;
      SLOT_FULL:  if (rd_ready && !fill) state_nxt = SLOT_EMPTY;
      default:    state_nxt = SLOT_EMPTY;
    endcase
  end

  // A full slot is writable only when it drains on the same edge.
  always_comb begin
    valid = (state == SLOT_FULL);
    wr_ok = (state == SLOT_EMPTY) || rd_ready;
    fill  = wr_en && wr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data <= '0;
    else if (fill) data <= wr_data;
  end

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 stream demultiplexer: one valid/ready input routed by
// sel into four independently drained one-entry output slots.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int unsigned width  = DEFAULT_WIDTH,
  parameter int unsigned swidth = DEFAULT_SWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [width-1:0]  in_data,
  input  logic [swidth-1:0] sel,
  output logic [width-1:0]  o0,
  output logic [width-1:0]  o1,
  output logic [width-1:0]  o2,
  output logic [width-1:0]  o3,
  output logic [3:0]        o_valid,
  input  logic [3:0]        o_ready
);

  logic [CH_NUM-1:0] wr_en;
  logic [CH_NUM-1:0] wr_ok;
  logic [width-1:0]  slot_data [CH_NUM];

  always_comb begin
    wr_en = in_valid ? sel_decode(sel) : '0;
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
    demux_slot #(
      .width(width)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[k]),
      .wr_data (in_data),
      .rd_ready(o_ready[k]),
      .valid   (o_valid[k]),
      .data    (slot_data[k]),
      .wr_ok   (wr_ok[k])
    );
  end

  always_comb begin
    in_ready = wr_ok[sel];
    o0       = slot_data[0];
    o1       = slot_data[1];
    o2       = slot_data[2];
    o3       = slot_data[3];
  end

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Directed vector table plus reset sequences and a random scoreboard run
// for the registered 1-to-4 stream demultiplexer.
module tb_demux_1to4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] sel;
  logic [3:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic [3:0] o_arr [4];

  int errors = 0;
  int checks = 0;

  demux_1to4_reg #(
    .width (4),
    .swidth(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .sel     (sel),
    .o0      (o0),
    .o1      (o1),
    .o2      (o2),
    .o3      (o3),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;

  assign o_arr[0] = o0;
  assign o_arr[1] = o1;
  assign o_arr[2] = o2;
  assign o_arr[3] = o3;

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       ir;
    logic [3:0] ov;
    logic [3:0] dmask;
    logic [15:0] od;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [1:0] s, logic [3:0] d, logic [3:0] ordy,
                              logic ir, logic [3:0] ov, logic [3:0] dmask, logic [15:0] od);
    vec_t v;
    v.iv = iv; v.sel = s; v.d = d; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.dmask = dmask; v.od = od;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer rule: a refused word must be presented unchanged on the next edge.
  logic       pend = 1'b0;
  logic [3:0] pd;
  logic [1:0] ps;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if (!(in_valid && in_data == pd && sel == ps)) begin
          errors++;
          $display("FAIL protocol: in_valid=%0b sel=%0d data=%0h held sel=%0d data=%0h",
                   in_valid, sel, in_data, ps, pd);
        end
      end
      pend = in_valid && !in_ready;
      pd   = in_data;
      ps   = sel;
    end
  end

  logic       mfull [4];
  logic [3:0] mdata [4];
  int         sent = 0;
  int         rcvd = 0;
  logic       pending;
  logic       exp_ir;
  logic [3:0] exp_ov;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; sel = 2'd2; in_data = 4'hF; o_ready = 4'hF;
    #3;
    chk("reset_o_valid", 32'(o_valid), 32'h0);
    chk("reset_o_data", {16'h0, o3, o2, o1, o0}, 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);

    // First edge after release accepts the word already presented.
    @(negedge clk); rst_n = 1'b1;
    #1 chk("release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("release_o_valid", 32'(o_valid), 32'h4);
    chk("release_o2", 32'(o2), 32'hF);

    // iv sel d ordy | ir ov dmask od{o3,o2,o1,o0}
    vecs.push_back(mk(1, 0, 4'hA, 4'hF, 1, 4'b0001, 4'b0001, 16'h000A));
    vecs.push_back(mk(1, 1, 4'h5, 4'hF, 1, 4'b0010, 4'b0011, 16'h005A));
    vecs.push_back(mk(1, 2, 4'hC, 4'hF, 1, 4'b0100, 4'b0100, 16'h0C00));
    vecs.push_back(mk(1, 3, 4'h3, 4'hF, 1, 4'b1000, 4'b1000, 16'h3000));
    vecs.push_back(mk(0, 0, 4'h0, 4'hF, 1, 4'b0000, 4'b0000, 16'h0000));
    vecs.push_back(mk(1, 2, 4'h7, 4'hB, 1, 4'b0100, 4'b0100, 16'h0700));
    vecs.push_back(mk(1, 0, 4'h1, 4'hB, 1, 4'b0101, 4'b0101, 16'h0701));
    vecs.push_back(mk(1, 2, 4'h9, 4'hB, 0, 4'b0100, 4'b0100, 16'h0700));
    vecs.push_back(mk(1, 2, 4'h9, 4'hB, 0, 4'b0100, 4'b0100, 16'h0700));
    vecs.push_back(mk(1, 2, 4'h9, 4'hF, 1, 4'b0100, 4'b0100, 16'h0900));
    vecs.push_back(mk(0, 0, 4'h0, 4'hF, 1, 4'b0000, 4'b0000, 16'h0000));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 1, 4'(i), 4'hF, 1, 4'b0010, 4'b0010, {8'h0, 4'(i), 4'h0}));
    vecs.push_back(mk(0, 1, 4'h0, 4'hF, 1, 4'b0000, 4'b0000, 16'h0000));
    vecs.push_back(mk(1, 0, 4'hF, 4'h0, 1, 4'b0001, 4'b0001, 16'h000F));
    vecs.push_back(mk(1, 1, 4'hF, 4'h0, 1, 4'b0011, 4'b0011, 16'h00FF));
    vecs.push_back(mk(1, 2, 4'hF, 4'h0, 1, 4'b0111, 4'b0111, 16'h0FFF));
    vecs.push_back(mk(1, 3, 4'hF, 4'h0, 1, 4'b1111, 4'b1111, 16'hFFFF));
    vecs.push_back(mk(0, 1, 4'h0, 4'h0, 0, 4'b1111, 4'b1111, 16'hFFFF));

    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid = vecs[i].iv; sel = vecs[i].sel; in_data = vecs[i].d; o_ready = vecs[i].ordy;
      #1 chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_o_valid", i), 32'(o_valid), 32'(vecs[i].ov));
      for (int k = 0; k < 4; k++)
        if (vecs[i].dmask[k])
          chk($sformatf("vec%0d_o%0d", i, k), 32'(o_arr[k]), 32'(vecs[i].od[4*k +: 4]));
    end

    // Reset pulse between edges with all four slots full.
    @(negedge clk); in_valid = 1'b0; o_ready = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_o_valid", 32'(o_valid), 32'h0);
    chk("midreset_o_data", {16'h0, o3, o2, o1, o0}, 32'h0);
    chk("midreset_in_ready", 32'(in_ready), 32'h1);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); o_ready = 4'hF;
      @(posedge clk); #1;
      chk("postreset_o_valid", 32'(o_valid), 32'h0);
    end

    // Random traffic against a one-entry-per-channel model.
    for (int k = 0; k < 4; k++) begin mfull[k] = 1'b0; mdata[k] = 4'h0; end
    pending = 1'b0;
    for (int c = 0; c < 3010; c++) begin
      @(negedge clk);
      if (!pending) begin
        in_valid = (c < 3000) ? 1'($urandom_range(0, 1)) : 1'b0;
        sel      = 2'($urandom_range(0, 3));
        in_data  = 4'($urandom_range(0, 15));
      end
      o_ready = (c < 3000) ? 4'($urandom_range(0, 15)) : 4'hF;
      #1;
      exp_ir = !mfull[sel] || o_ready[sel];
      exp_ov = {mfull[3], mfull[2], mfull[1], mfull[0]};
      chk("rnd_in_ready", 32'(in_ready), 32'(exp_ir));
      chk("rnd_o_valid", 32'(o_valid), 32'(exp_ov));
      for (int k = 0; k < 4; k++)
        if (mfull[k] && o_ready[k]) begin
          chk($sformatf("rnd_o%0d", k), 32'(o_arr[k]), 32'(mdata[k]));
          rcvd++;
          mfull[k] = 1'b0;
        end
      if (in_valid && exp_ir) begin
        mfull[sel] = 1'b1;
        mdata[sel] = in_data;
        sent++;
      end
      pending = in_valid && !exp_ir;
      @(posedge clk);
    end
    #1;
    chk("rnd_sent_eq_rcvd", 32'(sent), 32'(rcvd));
    chk("rnd_drained_o_valid", 32'(o_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
